// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch resolution and program sequencing for the fetch stage
//
// Drives the fetch stage's init/branch_en/bSIGN/bOFFSET/halt controls from
// the current instruction, registered ALU flags and a loadable offset table,
// and runs the IDLE -> INIT -> RUN -> HALT program sequence.
//
// Ports:
//   CLK, RST_N       clock (rising edge) and asynchronous active-low reset
//   start            single-cycle request to begin (or restart) a program
//   instr            9-bit instruction at PC; instr_valid qualifies it
//   PC               current fetch-stage program counter
//   flag_we          capture alu_zero/alu_neg into Z/N at this edge
//   lut_we           write lut_data into offset table entry lut_addr
//   init             fetch-stage PC reset request (held during INIT)
//   branch_en        take branch this cycle (combinational, same cycle as instr)
//   bSIGN, bOFFSET   branch direction (1 = backward) and magnitude
//   halt             program halted
//   done             one-cycle pulse on entry to HALT
//   cycle_count      RUN cycles since last start, saturating at 16'hFFFF

module branch_ctrl #(
    parameter int         INIT_CYCLES = 2,
    parameter logic [9:0] MAX_PC      = 10'd1023,
    parameter int         OFS_W       = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [8:0]       instr,
    input  logic             instr_valid,
    input  logic [9:0]       PC,
    input  logic             flag_we,
    input  logic             alu_zero,
    input  logic             alu_neg,
    input  logic             lut_we,
    input  logic [3:0]       lut_addr,
    input  logic [OFS_W-1:0] lut_data,
    output logic             init,
    output logic             branch_en,
    output logic             bSIGN,
    output logic [OFS_W-1:0] bOFFSET,
    output logic             halt,
    output logic             done,
    output logic [15:0]      cycle_count
);

    localparam int CNT_W = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES + 1);

    localparam logic [3:0] OP_JMP = 4'b1101;
    localparam logic [3:0] OP_BEQ = 4'b1110;
    localparam logic [3:0] OP_BLT = 4'b1111;
    localparam logic [8:0] HALT_INSTR = 9'h1FF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_HALT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   init_cnt;
    logic               init_r;
    logic               halt_r;
    logic               done_r;
    logic [15:0]        cycle_cnt_r;

    logic               z_flag;
    logic               n_flag;
    logic [OFS_W-1:0]   lut [16];

    // Instruction fields
    logic [3:0]         opcode;
    logic               sgn;
    logic [3:0]         idx;
    logic               in_run;
    logic               is_halt_instr;
    logic               halt_req;
    logic               take;

    assign opcode        = instr[8:5];
    assign sgn           = instr[4];
    assign idx           = instr[3:0];
    assign in_run        = (state == S_RUN);
    assign is_halt_instr = instr_valid && (instr == HALT_INSTR);
    assign halt_req      = in_run && (is_halt_instr || (PC == MAX_PC));

    // The halt instruction shares the BLT opcode, so it is excluded
    // explicitly to keep it from ever branching.
    always_comb begin
        take = 1'b0;
        if (in_run && instr_valid && !is_halt_instr) begin
            case (opcode)
                OP_JMP:  take = 1'b1;
                OP_BEQ:  take = z_flag;
                OP_BLT:  take = n_flag;
                default: take = 1'b0;
            endcase
        end
    end

    // Branch outputs are combinational so the fetch stage sees them in the
    // same cycle as instr and applies them at the next edge.
    assign branch_en   = take;
    assign bSIGN       = take & sgn;
    assign bOFFSET     = take ? lut[idx] : '0;

    assign init        = init_r;
    assign halt        = halt_r;
    assign done        = done_r;
    assign cycle_count = cycle_cnt_r;

    // Program sequencer with registered init/halt/done
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            init_cnt    <= '0;
            init_r      <= 1'b0;
            halt_r      <= 1'b0;
            done_r      <= 1'b0;
            cycle_cnt_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_INIT;
                        init_cnt    <= CNT_W'(INIT_CYCLES);
                        init_r      <= 1'b1;
                        cycle_cnt_r <= '0;
                    end
                end
                S_INIT: begin
                    // init_cnt holds the INIT cycles remaining including this one
                    if (init_cnt <= CNT_W'(1)) begin
                        state  <= S_RUN;
                        init_r <= 1'b0;
                    end else begin
                        init_cnt <= init_cnt - CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (cycle_cnt_r != 16'hFFFF) begin
                        cycle_cnt_r <= cycle_cnt_r + 16'd1;
                    end
                    if (halt_req) begin
                        state  <= S_HALT;
                        halt_r <= 1'b1;
                        done_r <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (start) begin
                        state       <= S_INIT;
                        init_cnt    <= CNT_W'(INIT_CYCLES);
                        init_r      <= 1'b1;
                        halt_r      <= 1'b0;
                        cycle_cnt_r <= '0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    init_r <= 1'b0;
                    halt_r <= 1'b0;
                end
            endcase
        end
    end

    // ALU flags; a branch in the capture cycle still sees the previous values
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            z_flag <= 1'b0;
            n_flag <= 1'b0;
        end else if (flag_we) begin
            z_flag <= alu_zero;
            n_flag <= alu_neg;
        end
    end

    // Offset table; resets to entry i = i+1 so branches work before any load
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 16; i++) begin
                lut[i] <= OFS_W'(i + 1);
            end
        end else if (lut_we) begin
            lut[lut_addr] <= lut_data;
        end
    end

endmodule
